// File: rtl/conv_addr_gen.sv
// conv_addr_gen: sliding KxK window address generator for the convolution datapath.
// Scans every window position of an IMG_H x IMG_W row-major image and emits one
// pixel address per accepted valid/ready handshake, flagging the first and last
// address of each window so the MAC stage knows when to start and flush.
// Optional feature: define CONV_ADDR_STALL_CNT_EN to add a saturating stall_cnt output
// that counts cycles where addr_valid=1 and addr_ready=0.
module conv_addr_gen #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int K      = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              win_first,
    output logic              win_last,
    output logic              busy,
    output logic              done
`ifdef CONV_ADDR_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // Counter widths; a width of at least one bit keeps degenerate sizes legal.
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [RW-1:0] r_row, w_row_next;
    logic [CW-1:0] r_col, w_col_next;
    logic [KW-1:0] r_kr,  w_kr_next;
    logic [KW-1:0] r_kc,  w_kc_next;

    logic w_xfer;
    logic w_start_acc;
    logic w_kc_wrap;
    logic w_kr_wrap;
    logic w_col_wrap;
    logic w_row_wrap;
    logic w_last_xfer;

    assign w_xfer      = (r_state == S_RUN) && addr_ready;
    assign w_start_acc = (r_state == S_IDLE) && start;

    // Terminal values of each counter in the nested kc -> kr -> c -> r chain.
    assign w_kc_wrap   = (r_kc  == KW'(K - 1));
    assign w_kr_wrap   = (r_kr  == KW'(K - 1));
    assign w_col_wrap  = (r_col == CW'(IMG_W - K));
    assign w_row_wrap  = (r_row == RW'(IMG_H - K));
    assign w_last_xfer = w_kc_wrap && w_kr_wrap && w_col_wrap && w_row_wrap;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; clr overrides everything except rst.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_RUN;
            S_RUN:  if (w_xfer && w_last_xfer) w_state_next = S_FIN;
            S_FIN:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (clr) begin
            w_state_next = S_IDLE;
        end
    end

    // Counter next values: cleared on abort/start, advanced only on a transfer.
    // The final transfer wraps every counter, leaving them at zero for IDLE.
    always_comb begin
        w_row_next = r_row;
        w_col_next = r_col;
        w_kr_next  = r_kr;
        w_kc_next  = r_kc;
        if (clr || w_start_acc) begin
            w_row_next = '0;
            w_col_next = '0;
            w_kr_next  = '0;
            w_kc_next  = '0;
        end else if (w_xfer) begin
            if (w_kc_wrap) begin
                w_kc_next = '0;
                if (w_kr_wrap) begin
                    w_kr_next = '0;
                    if (w_col_wrap) begin
                        w_col_next = '0;
                        w_row_next = w_row_wrap ? '0 : r_row + 1'b1;
                    end else begin
                        w_col_next = r_col + 1'b1;
                    end
                end else begin
                    w_kr_next = r_kr + 1'b1;
                end
            end else begin
                w_kc_next = r_kc + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
            r_kr  <= '0;
            r_kc  <= '0;
        end else begin
            r_row <= w_row_next;
            r_col <= w_col_next;
            r_kr  <= w_kr_next;
            r_kc  <= w_kc_next;
        end
    end

    // Outputs are pure functions of registered state, so they hold during stalls.
    assign addr_valid = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_FIN);
    assign addr       = ADDR_W'((32'(r_row) + 32'(r_kr)) * 32'(IMG_W)
                               + 32'(r_col) + 32'(r_kc));
    assign win_first  = addr_valid && (r_kr == '0) && (r_kc == '0);
    assign win_last   = addr_valid && w_kr_wrap && w_kc_wrap;

`ifdef CONV_ADDR_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of back-pressured cycles; restarts with each scan.
    always_ff @(posedge clk) begin
        if (rst || clr || w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !addr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_addr_gen.sv
// tb_conv_addr_gen: scoreboard bench for conv_addr_gen. A nested-loop reference
// model pushes the expected {win_first, win_last, addr} sequence when a scan is
// started; each observed transfer pops and compares one entry.
module tb_conv_addr_gen;

    localparam int IMG_W  = 16;
    localparam int IMG_H  = 16;
    localparam int K      = 3;
    localparam int ADDR_W = 8;
    localparam int BUDGET = 20000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              clr = 1'b0;
    logic              addr_ready = 1'b0;
    logic              addr_valid;
    logic [ADDR_W-1:0] addr;
    logic              win_first;
    logic              win_last;
    logic              busy;
    logic              done;
`ifdef CONV_ADDR_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W+1:0] exp_q[$];
    int first_tbl[10] = '{0, 1, 2, 16, 17, 18, 32, 33, 34, 1};

    conv_addr_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .clr(clr),
        .addr_ready(addr_ready),
        .addr_valid(addr_valid),
        .addr(addr),
        .win_first(win_first),
        .win_last(win_last),
        .busy(busy),
        .done(done)
`ifdef CONV_ADDR_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push_model();
        for (int r = 0; r <= IMG_H - K; r++)
            for (int c = 0; c <= IMG_W - K; c++)
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        exp_q.push_back({(kr == 0 && kc == 0), (kr == K-1 && kc == K-1),
                                         ADDR_W'((r + kr) * IMG_W + c + kc)});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(addr_valid), 0);
        chk({tag, "_addr"},  32'(addr), 0);
        chk({tag, "_first"}, 32'(win_first), 0);
        chk({tag, "_last"},  32'(win_last), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
    endtask

    // One scan: ready_mode 1 = random back-pressure; abort_at>0 aborts after that
    // many transfers (kind 0 = clr, 1 = rst); spam drives start during RUN/FIN.
    task automatic run_scan(input string name, input int ready_mode, input int abort_at,
                            input int abort_kind, input int spam, input int use_tbl);
        int xfers = 0;
        int stalls = 0;
        int cyc = 0;
        bit stalled = 0;
        bit finished = 0;
        logic [ADDR_W-1:0] held = '0;
        logic [ADDR_W+1:0] e;

        @(negedge clk);
        rst = 0; clr = 0; start = 1; addr_ready = 1;
        exp_q.delete();
        push_model();
        @(negedge clk);
        start = 0;
        chk("valid_rise", 32'(addr_valid), 1);
        chk("first_addr", 32'(addr), 0);

        while (!finished) begin
            if (abort_at > 0 && xfers == abort_at) begin
                if (abort_kind == 0) clr = 1; else rst = 1;
                start = spam ? 1'b1 : 1'b0;
                addr_ready = 1;
                @(negedge clk);
                clr = 0; rst = 0; start = 0;
                check_idle_outputs(abort_kind == 0 ? "clr" : "rst");
                @(negedge clk);
                chk("abort_stay_idle", 32'(addr_valid), 0);
                chk("abort_no_done", 32'(done), 0);
                $display("[TB] %s: aborted after %0d transfers", name, xfers);
                exp_q.delete();
                return;
            end
            if (cyc >= BUDGET) begin
                chk("timeout", 1, 0);
                exp_q.delete();
                return;
            end
            cyc++;
            chk("valid_run", 32'(addr_valid), 1);
            chk("busy_run", 32'(busy), 1);
            chk("done_low", 32'(done), 0);
            if (stalled) chk("stall_hold", 32'(addr), 32'(held));

            addr_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!addr_ready) begin
                stalls++;
                stalled = 1;
                held = addr;
            end else begin
                stalled = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                    finished = 1;
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer", 32'({win_first, win_last, addr}), 32'(e));
                    if (use_tbl && xfers < 10) chk("first_tbl", 32'(addr), 32'(first_tbl[xfers]));
                    xfers++;
                    if (exp_q.size() == 0) begin
                        chk("final_addr", 32'(addr), IMG_W * IMG_H - 1);
                        chk("final_last", 32'(win_last), 1);
                        finished = 1;
                    end
                end
            end
            @(negedge clk);
        end

        // One cycle after the final transfer: FIN.
        chk("xfer_count", xfers, (IMG_H-K+1) * (IMG_W-K+1) * K * K);
        chk("fin_done", 32'(done), 1);
        chk("fin_valid", 32'(addr_valid), 0);
        chk("fin_busy", 32'(busy), 0);
`ifdef CONV_ADDR_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), stalls);
`endif
        start = spam ? 1'b1 : 1'b0;
        addr_ready = 1;
        @(negedge clk);
        start = 0;
        chk("done_pulse_end", 32'(done), 0);
        chk("idle_valid", 32'(addr_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("no_restart", 32'(addr_valid), 0);
        $display("[TB] %s: %0d transfers, %0d stall cycles", name, xfers, stalls);
    endtask

    initial begin
        // Reset state.
        rst = 1; start = 0; clr = 0; addr_ready = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        $display("[TB] reset: outputs checked");

        run_scan("scan_nostall", 0, 0, 0, 0, 1);
        run_scan("scan_random_stall", 1, 0, 0, 0, 0);
        run_scan("scan_clr_at_100", 1, 100, 0, 0, 0);
        run_scan("scan_after_clr_spam", 0, 0, 0, 1, 0);

        // rst together with start: rst wins, block stays idle.
        @(negedge clk);
        rst = 1; start = 1; addr_ready = 1;
        @(negedge clk);
        rst = 0; start = 0;
        check_idle_outputs("rst_start");
        @(negedge clk);
        chk("rst_start_idle", 32'(addr_valid), 0);
        $display("[TB] rst_with_start: checked");

        run_scan("scan_rst_at_300", 0, 300, 1, 1, 0);
        run_scan("scan_after_rst", 1, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_addr_gen.md
Name: conv_addr_gen

Overview:
- Window address generator for the convolution datapath.
- Scans a KxK kernel window across an IMG_H x IMG_W image stored row-major in a flat memory, and emits one pixel address per accepted handshake.
- Sits directly downstream of the loop counters. Its row/column/kernel counters are built from the same clear/load/enable/carry counter style, and its addresses feed the image memory read port.
- Signals window boundaries so the MAC stage can accumulate and flush.

Parameters:
- IMG_W, 16, image width in pixels
- IMG_H, 16, image height in pixels
- K, 3, kernel edge length (window is KxK)
- ADDR_W, 8, address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a full-image scan; sampled only in IDLE
- clr  input  1  synchronous abort; returns the block to IDLE
- addr_ready  input  1  consumer accepts addr this cycle
- addr_valid  output  1  addr is valid
- addr  output  ADDR_W  pixel address = (r+kr)*IMG_W + (c+kc)
- win_first  output  1  current addr is the first of its window (kr=0, kc=0)
- win_last  output  1  current addr is the last of its window (kr=K-1, kc=K-1)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the final transfer

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- Reset values: state=IDLE; r, c, kr, kc = 0; addr_valid=0; addr=0; win_first=0; win_last=0; busy=0; done=0.
- rst has priority over clr. clr has priority over start and handshakes.
- FSM states: IDLE, RUN, FIN.
  - IDLE: if start=1, load counters to 0 and go to RUN next cycle. addr_valid rises the cycle after start.
  - RUN: addr_valid=1 and busy=1. A transfer occurs when addr_valid and addr_ready are both high. On each transfer, advance counters in nested order:
    - kc increments first.
    - When kc wraps (K-1 -> 0), kr increments.
    - When kr wraps, c increments.
    - When c wraps (IMG_W-K -> 0), r increments.
  - RUN, final transfer: the transfer at r=IMG_H-K, c=IMG_W-K, kr=K-1, kc=K-1 moves the FSM to FIN. addr_valid drops on the next cycle.
  - FIN: done=1 for exactly one cycle, then go to IDLE. start is ignored in FIN.
- addr, win_first and win_last are registered and combinationally tied to the current counter values. They stay stable while addr_valid=1 and addr_ready=0; no counter moves on a stall.
- Arithmetic: compute addr at full precision, then truncate to ADDR_W. The parameter constraint guarantees no overflow.
- Boundary conditions:
  - Window count = (IMG_H-K+1)*(IMG_W-K+1). Transfers per scan = that count * K*K.
  - K=1 is legal: win_first=win_last=1 on every address.
  - start asserted in RUN or FIN has no effect.
  - clr mid-scan: next cycle addr_valid=0, counters=0, state=IDLE, and no done pulse.
  - rst mid-scan: identical to clr, and also clears all outputs.
  - addr_ready held high: one transfer per cycle, no bubbles, including across window and row wraps.

Optional Feature:
- Macro: CONV_ADDR_STALL_CNT_EN
- When defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with addr_valid=1 and addr_ready=0, saturating at 16'hFFFF.
  - Cleared by rst, by clr, and on the start-accept cycle; holds its value in IDLE and FIN.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, rst then start pulse, addr_ready=1 -> first 9 addrs are 0,1,2,16,17,18,32,33,34; win_first on 0; win_last on 34; next window starts at 1.
- Full scan with addr_ready=1 -> exactly 1764 transfers; final addr=255 with win_last=1; done pulses once, 1 cycle after the final transfer; busy=0 after.
- addr_ready toggled pseudo-randomly -> address sequence identical to the no-stall run; addr stable during stalls. With CONV_ADDR_STALL_CNT_EN, stall_cnt equals the number of stall cycles.
- clr asserted at transfer 100 -> addr_valid=0 next cycle, no done pulse; a subsequent start restarts at addr 0.
- rst asserted together with start, and mid-scan -> rst wins; all outputs reset next edge; block remains IDLE.
- start re-asserted during RUN and FIN -> ignored; sequence and the single done pulse are unaffected.
